// File: rtl/vga_frame_swap_pkg.sv
// Shared types and limits for the VGA ping-pong framebuffer swap controller.
package vga_frame_swap_pkg;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWAP    = 2'd2
  } swap_state_t;

  localparam int MAX_RD_LATENCY = 3;

endpackage

// File: rtl/vga_rdata_sel_pipe.sv
// Delays front_sel by the BRAM read latency so returning read data is steered
// by the buffer that was front when the read was issued.
module vga_rdata_sel_pipe #(
  parameter int RD_LATENCY = 1
) (
  input  logic vga_clk,
  input  logic rst_n,
  input  logic sel_in,
  output logic sel_out
);

  logic [RD_LATENCY-1:0] sel_q;
  logic [RD_LATENCY-1:0] sel_d;

  always_comb begin
    sel_d    = sel_q;
    sel_d[0] = sel_in;
    for (int i = 1; i < RD_LATENCY; i++) begin
      sel_d[i] = sel_q[i-1];
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign sel_out = sel_q[RD_LATENCY-1];

endmodule

// File: rtl/vga_frame_swap_ctrl.sv
// Ping-pong framebuffer controller: scan-out reads the front buffer, the writer
// fills the back buffer, swap at vblank. Stats counters under VGA_FRAME_SWAP_STATS_EN.
module vga_frame_swap_ctrl
  import vga_frame_swap_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  vga_clk,
  input  logic                  rst_n,
  input  logic                  vblank_start,
  input  logic                  frame_done,
  output logic                  vga_ready,
  output logic                  front_sel,
  input  logic [ADDR_WIDTH-1:0] vga_raddr,
  input  logic                  vga_rden,
  output logic [DATA_WIDTH-1:0] vga_rdata,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] buf0_raddr,
  output logic [ADDR_WIDTH-1:0] buf1_raddr,
  output logic                  buf0_rden,
  output logic                  buf1_rden,
  input  logic [DATA_WIDTH-1:0] buf0_rdata,
  input  logic [DATA_WIDTH-1:0] buf1_rdata,
  output logic [ADDR_WIDTH-1:0] buf0_waddr,
  output logic [ADDR_WIDTH-1:0] buf1_waddr,
  output logic                  buf0_wen,
  output logic                  buf1_wen,
  output logic [DATA_WIDTH-1:0] buf0_wdata,
  output logic [DATA_WIDTH-1:0] buf1_wdata
`ifdef VGA_FRAME_SWAP_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  swap_count,
  output logic [CNT_WIDTH-1:0]  repeat_count
`endif
);

  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY || CNT_WIDTH < 1) begin : g_bad_param
    $error("vga_frame_swap_ctrl: RD_LATENCY must be 1..3 and CNT_WIDTH >= 1");
  end

  swap_state_t           state_q, state_d;
  logic                  front_sel_q, front_sel_d;
  logic                  vga_ready_q, vga_ready_d;
  logic                  buf0_wen_q, buf0_wen_d;
  logic                  buf1_wen_q, buf1_wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_accept;
  logic                  rd_sel;

  // The swap itself happens on leaving ST_SWAP, one cycle after the vblank
  // that was seen in ST_PENDING, so the last registered write has landed.
  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel_q;
    unique case (state_q)
      ST_FREE:    if (frame_done)   state_d = ST_PENDING;
      ST_PENDING: if (vblank_start) state_d = ST_SWAP;
      ST_SWAP: begin
        state_d     = ST_FREE;
        front_sel_d = ~front_sel_q;
      end
      default:    state_d = ST_FREE;
    endcase
    vga_ready_d = (state_d == ST_FREE);
  end

  always_comb begin
    wr_accept  = wr_en && vga_ready_q;
    buf0_wen_d = wr_accept && front_sel_q;
    buf1_wen_d = wr_accept && !front_sel_q;
    waddr_d    = wr_accept ? wr_addr : waddr_q;
    wdata_d    = wr_accept ? wr_data : wdata_q;
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FREE;
      front_sel_q <= 1'b0;
      vga_ready_q <= 1'b1;
      buf0_wen_q  <= 1'b0;
      buf1_wen_q  <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      vga_ready_q <= vga_ready_d;
      buf0_wen_q  <= buf0_wen_d;
      buf1_wen_q  <= buf1_wen_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  vga_rdata_sel_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_sel_pipe (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .sel_in  (front_sel_q),
    .sel_out (rd_sel)
  );

  assign front_sel  = front_sel_q;
  assign vga_ready  = vga_ready_q;
  assign buf0_raddr = vga_raddr;
  assign buf1_raddr = vga_raddr;
  assign buf0_rden  = vga_rden && !front_sel_q;
  assign buf1_rden  = vga_rden && front_sel_q;
  assign vga_rdata  = rd_sel ? buf1_rdata : buf0_rdata;
  assign buf0_wen   = buf0_wen_q;
  assign buf1_wen   = buf1_wen_q;
  assign buf0_waddr = waddr_q;
  assign buf1_waddr = waddr_q;
  assign buf0_wdata = wdata_q;
  assign buf1_wdata = wdata_q;

`ifdef VGA_FRAME_SWAP_STATS_EN
  logic [CNT_WIDTH-1:0] swap_count_q, swap_count_d;
  logic [CNT_WIDTH-1:0] repeat_count_q, repeat_count_d;

  always_comb begin
    swap_count_d   = swap_count_q;
    repeat_count_d = repeat_count_q;
    if (state_q == ST_PENDING && vblank_start) swap_count_d = swap_count_q + 1'b1;
    if (state_q == ST_FREE && vblank_start)    repeat_count_d = repeat_count_q + 1'b1;
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_count_q   <= '0;
      repeat_count_q <= '0;
    end else begin
      swap_count_q   <= swap_count_d;
      repeat_count_q <= repeat_count_d;
    end
  end

  assign swap_count   = swap_count_q;
  assign repeat_count = repeat_count_q;
`endif

endmodule

// File: tb/tb_vga_frame_swap_ctrl.sv
// Directed bench for vga_frame_swap_ctrl with two behavioural 2-cycle BRAMs.
module tb_vga_frame_swap_ctrl;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int CW  = 16;

  logic          vga_clk = 1'b0;
  logic          rst_n;
  logic          vblank_start, frame_done;
  logic          vga_ready, front_sel;
  logic [AW-1:0] vga_raddr;
  logic          vga_rden;
  logic [DW-1:0] vga_rdata;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] buf0_raddr, buf1_raddr, buf0_waddr, buf1_waddr;
  logic          buf0_rden, buf1_rden, buf0_wen, buf1_wen;
  logic [DW-1:0] buf0_rdata = '0, buf1_rdata = '0;
  logic [DW-1:0] buf0_wdata, buf1_wdata;
`ifdef VGA_FRAME_SWAP_STATS_EN
  logic [CW-1:0] swap_count, repeat_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] p0 = '0, p1 = '0;

  always #5 vga_clk = ~vga_clk;

  vga_frame_swap_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LATENCY (LAT),
    .CNT_WIDTH  (CW)
  ) dut (
    .vga_clk      (vga_clk),
    .rst_n        (rst_n),
    .vblank_start (vblank_start),
    .frame_done   (frame_done),
    .vga_ready    (vga_ready),
    .front_sel    (front_sel),
    .vga_raddr    (vga_raddr),
    .vga_rden     (vga_rden),
    .vga_rdata    (vga_rdata),
    .wr_addr      (wr_addr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .buf0_raddr   (buf0_raddr),
    .buf1_raddr   (buf1_raddr),
    .buf0_rden    (buf0_rden),
    .buf1_rden    (buf1_rden),
    .buf0_rdata   (buf0_rdata),
    .buf1_rdata   (buf1_rdata),
    .buf0_waddr   (buf0_waddr),
    .buf1_waddr   (buf1_waddr),
    .buf0_wen     (buf0_wen),
    .buf1_wen     (buf1_wen),
    .buf0_wdata   (buf0_wdata),
    .buf1_wdata   (buf1_wdata)
`ifdef VGA_FRAME_SWAP_STATS_EN
    ,
    .swap_count   (swap_count),
    .repeat_count (repeat_count)
`endif
  );

  // Behavioural BRAMs with a two-cycle registered read.
  always @(posedge vga_clk) begin
    if (buf0_wen) mem0[buf0_waddr[7:0]] <= buf0_wdata;
    if (buf1_wen) mem1[buf1_waddr[7:0]] <= buf1_wdata;
    if (buf0_rden) p0 <= mem0[buf0_raddr[7:0]];
    if (buf1_rden) p1 <= mem1[buf1_raddr[7:0]];
    buf0_rdata <= p0;
    buf1_rdata <= p1;
  end

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic pulse_frame_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic pulse_vblank();
    vblank_start = 1'b1;
    tick();
    vblank_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL rst_front_sel got=%0h want=0", front_sel); end
    checks++; if (vga_ready !== 1'b1) begin errors++; $display("FAIL rst_vga_ready got=%0h want=1", vga_ready); end
    checks++; if ({buf0_wen, buf1_wen, buf0_rden, buf1_rden} !== 4'b0000) begin errors++; $display("FAIL rst_wen_rden got=%b want=0000", {buf0_wen, buf1_wen, buf0_rden, buf1_rden}); end
    checks++; if (buf0_waddr !== '0 || buf1_wdata !== '0) begin errors++; $display("FAIL rst_wr_regs got=%0h/%0h want=0/0", buf0_waddr, buf1_wdata); end
    checks++; if (vga_rdata !== '0) begin errors++; $display("FAIL rst_vga_rdata got=%0h want=0", vga_rdata); end
`ifdef VGA_FRAME_SWAP_STATS_EN
    checks++; if (swap_count !== '0 || repeat_count !== '0) begin errors++; $display("FAIL rst_stats got=%0d/%0d want=0/0", swap_count, repeat_count); end
`endif
    repeat (2) @(posedge vga_clk);
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_swap();
    wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'h888;
    tick();
    wr_en = 1'b0;
    checks++; if (buf1_wen !== 1'b1 || buf0_wen !== 1'b0) begin errors++; $display("FAIL ws_wen got=%b%b want=10", buf1_wen, buf0_wen); end
    checks++; if (buf1_waddr !== 32'h10 || buf1_wdata !== 32'h888) begin errors++; $display("FAIL ws_waddr_wdata got=%0h/%0h want=10/888", buf1_waddr, buf1_wdata); end
    tick();
    checks++; if (buf1_wen !== 1'b0) begin errors++; $display("FAIL ws_wen_single got=%0h want=0", buf1_wen); end
    pulse_frame_done();
    checks++; if (vga_ready !== 1'b0) begin errors++; $display("FAIL ws_pending_ready got=%0h want=0", vga_ready); end
    pulse_vblank();
    checks++; if (front_sel !== 1'b0 || vga_ready !== 1'b0) begin errors++; $display("FAIL ws_t1 got=%0h/%0h want=0/0", front_sel, vga_ready); end
    tick();
    checks++; if (front_sel !== 1'b1 || vga_ready !== 1'b1) begin errors++; $display("FAIL ws_t2 got=%0h/%0h want=1/1", front_sel, vga_ready); end
    vga_rden = 1'b1; vga_raddr = 32'h10;
    #1;
    checks++; if (buf1_rden !== 1'b1 || buf0_rden !== 1'b0) begin errors++; $display("FAIL ws_rden got=%b%b want=10", buf1_rden, buf0_rden); end
    checks++; if (buf0_raddr !== 32'h10 || buf1_raddr !== 32'h10) begin errors++; $display("FAIL ws_raddr got=%0h/%0h want=10/10", buf0_raddr, buf1_raddr); end
    tick();
    vga_rden = 1'b0;
    tick();
    checks++; if (vga_rdata !== 32'h888) begin errors++; $display("FAIL ws_rdata got=%0h want=888", vga_rdata); end
  endtask

  task automatic test_repeat();
`ifdef VGA_FRAME_SWAP_STATS_EN
    checks++; if (repeat_count !== 16'd0) begin errors++; $display("FAIL rp_count_before got=%0d want=0", repeat_count); end
`endif
    pulse_vblank();
    tick();
    checks++; if (front_sel !== 1'b1 || vga_ready !== 1'b1) begin errors++; $display("FAIL rp_front got=%0h/%0h want=1/1", front_sel, vga_ready); end
`ifdef VGA_FRAME_SWAP_STATS_EN
    checks++; if (repeat_count !== 16'd1) begin errors++; $display("FAIL rp_count_after got=%0d want=1", repeat_count); end
`endif
  endtask

  task automatic test_dropped_writes();
    pulse_frame_done();
    wr_en = 1'b1; wr_addr = 32'h20; wr_data = 32'h123;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (buf0_wen !== 1'b0 || buf1_wen !== 1'b0) begin errors++; $display("FAIL dr_wen[%0d] got=%b%b want=00", i, buf1_wen, buf0_wen); end
    end
    wr_en = 1'b0;
    pulse_vblank();
    tick();
    checks++; if (front_sel !== 1'b0 || vga_ready !== 1'b1) begin errors++; $display("FAIL dr_swap got=%0h/%0h want=0/1", front_sel, vga_ready); end
`ifdef VGA_FRAME_SWAP_STATS_EN
    checks++; if (swap_count !== 16'd2) begin errors++; $display("FAIL dr_swap_count got=%0d want=2", swap_count); end
`endif
    wr_en = 1'b1; wr_addr = 32'h30; wr_data = 32'h55;
    tick();
    wr_en = 1'b0;
    checks++; if (buf1_wen !== 1'b1 || buf0_wen !== 1'b0) begin errors++; $display("FAIL dr_back_only got=%b%b want=10", buf1_wen, buf0_wen); end
    tick();
  endtask

  task automatic test_coincident();
    frame_done = 1'b1; vblank_start = 1'b1;
    tick();
    frame_done = 1'b0; vblank_start = 1'b0;
    checks++; if (vga_ready !== 1'b0 || front_sel !== 1'b0) begin errors++; $display("FAIL co_pending got=%0h/%0h want=0/0", vga_ready, front_sel); end
    repeat (2) tick();
    checks++; if (vga_ready !== 1'b0 || front_sel !== 1'b0) begin errors++; $display("FAIL co_hold got=%0h/%0h want=0/0", vga_ready, front_sel); end
    pulse_vblank();
    tick();
    checks++; if (front_sel !== 1'b1 || vga_ready !== 1'b1) begin errors++; $display("FAIL co_swap got=%0h/%0h want=1/1", front_sel, vga_ready); end
  endtask

  task automatic test_straddle();
    pulse_frame_done();
    pulse_vblank();
    vga_rden = 1'b1; vga_raddr = 32'h44;
    #1;
    checks++; if (buf1_rden !== 1'b1 || buf0_rden !== 1'b0) begin errors++; $display("FAIL st_rden_old got=%b%b want=10", buf1_rden, buf0_rden); end
    tick();
    vga_rden = 1'b0;
    checks++; if (front_sel !== 1'b0) begin errors++; $display("FAIL st_front got=%0h want=0", front_sel); end
    tick();
    checks++; if (vga_rdata !== 32'hB044) begin errors++; $display("FAIL st_rdata_old got=%0h want=b044", vga_rdata); end
    vga_rden = 1'b1;
    tick();
    vga_rden = 1'b0;
    tick();
    checks++; if (vga_rdata !== 32'hA044) begin errors++; $display("FAIL st_rdata_new got=%0h want=a044", vga_rdata); end
  endtask

  task automatic test_reset_mid();
    pulse_frame_done();
    pulse_vblank();
    tick();
    pulse_frame_done();
    checks++; if (front_sel !== 1'b1 || vga_ready !== 1'b0) begin errors++; $display("FAIL rm_pre got=%0h/%0h want=1/0", front_sel, vga_ready); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (front_sel !== 1'b0 || vga_ready !== 1'b1) begin errors++; $display("FAIL rm_async got=%0h/%0h want=0/1", front_sel, vga_ready); end
    checks++; if ({buf0_wen, buf1_wen, buf0_rden, buf1_rden} !== 4'b0000) begin errors++; $display("FAIL rm_wen_rden got=%b want=0000", {buf0_wen, buf1_wen, buf0_rden, buf1_rden}); end
    @(posedge vga_clk);
    #1 rst_n = 1'b1;
    tick();
    pulse_vblank();
    tick();
    checks++; if (front_sel !== 1'b0 || vga_ready !== 1'b1) begin errors++; $display("FAIL rm_discarded got=%0h/%0h want=0/1", front_sel, vga_ready); end
    wr_en = 1'b1; wr_addr = 32'h60; wr_data = 32'h77;
    tick();
    wr_en = 1'b0;
    checks++; if (buf1_wen !== 1'b1 || buf0_wen !== 1'b0 || buf1_waddr !== 32'h60) begin errors++; $display("FAIL rm_write got=%b%b@%0h want=10@60", buf1_wen, buf0_wen, buf1_waddr); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 32'hA000 + i;
      mem1[i] = 32'hB000 + i;
    end
    vblank_start = 1'b0; frame_done = 1'b0;
    vga_raddr = '0; vga_rden = 1'b0;
    wr_addr = '0; wr_en = 1'b0; wr_data = '0;
    test_reset();
    test_write_swap();
    test_repeat();
    test_dropped_writes();
    test_coincident();
    test_straddle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
